uncached_axi_bridge: RTL and testbench

- Downstream of the data-side store buffer.
- Converts the SRAM-like handshake (req/wr/size/addr/wdata/wstrb, addr_ok/data_ok) into single-beat AXI3 transactions for uncached and bypass accesses.
- One transaction in flight at a time, completed in order.
- Read data and write completion are returned as a one-cycle data_ok pulse.

---
 rtl/uncached_axi_bridge_if.sv | 75 +++++++
 rtl/uncached_axi_bridge.sv | 127 ++++++++++++
 tb/tb_uncached_axi_bridge.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uncached_axi_bridge_if.sv
// Bus bundle for the uncached bridge: SRAM-like upstream handshake plus single-beat AXI3.
// The master modport is the bridge's view; slave is the environment (store buffer + interconnect).
interface uncached_axi_bridge_if;
  // upstream SRAM-like side
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        bus_err;
  // AR / R
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata_i;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AW / W / B
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  req, wr, size, addr, wdata, wstrb,
    output addr_ok, data_ok, rdata, bus_err,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata_i, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata_o, wstrb_o, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    output req, wr, size, addr, wdata, wstrb,
    input  addr_ok, data_ok, rdata, bus_err,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata_i, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata_o, wstrb_o, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/uncached_axi_bridge.sv
// SRAM-like to single-beat AXI3 bridge for uncached/bypass accesses.
// One transaction in flight; completion is a one-cycle data_ok pulse.
module uncached_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  uncached_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_e;

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        aw_done_q, w_done_q;
  logic        data_ok_q, bus_err_q;
  logic        aw_done_d, w_done_d;
  logic        unused_rlast;

  // AW and W complete independently; either may finish first or both together
  assign aw_done_d = aw_done_q | (awvalid_q & bus.awready);
  assign w_done_d  = w_done_q  | (wvalid_q  & bus.wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.req) begin
          addr_q <= bus.addr;
          size_q <= bus.size;
          if (bus.wr) begin
            wdata_q   <= bus.wdata;
            wstrb_q   <= bus.wstrb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= AW_W;
          end else begin
            arvalid_q <= 1'b1;
            state_q   <= AR;
          end
        end
        AR: if (bus.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= R;
        end
        R: if (bus.rvalid) begin
          rready_q  <= 1'b0;
          rdata_q   <= bus.rdata_i;
          bus_err_q <= |bus.rresp;
          data_ok_q <= 1'b1;
          state_q   <= DONE;
        end
        AW_W: begin
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= B;
          end
        end
        B: if (bus.bvalid) begin
          bready_q  <= 1'b0;
          bus_err_q <= |bus.bresp;
          data_ok_q <= 1'b1;
          state_q   <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.addr_ok = (state_q == IDLE) & bus.req;
  assign bus.data_ok = data_ok_q;
  assign bus.bus_err = bus_err_q;
  assign bus.rdata   = rdata_q;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 4'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 4'd0;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = 2'b01;
  assign bus.awvalid = awvalid_q;
  assign bus.wid     = AXI_ID;
  assign bus.wdata_o = wdata_q;
  assign bus.wstrb_o = wstrb_q;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

  // single-beat responses only, so the last flag carries no information
  assign unused_rlast = bus.rlast;

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Bench for uncached_axi_bridge: vector table driven through a cycle-level AXI slave model,
// with a scoreboard of expected completions popped on each data_ok.
module tb_uncached_axi_bridge;

  logic clk;
  logic rst;
  uncached_axi_bridge_if bus();

  uncached_axi_bridge #(.AXI_ID(4'd1)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          d1;     // read: arready wait; write: awready wait
    int          d2;     // read: rvalid wait;  write: wready wait
    int          d3;     // write: bvalid wait
    logic [31:0] rdat;
    logic [1:0]  resp;
    logic        hold;   // keep req high while busy
    logic [2:0]  exp_axsize;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
  endtask

  function automatic int lat_of(input vec_t t);
    if (t.wr) return 3 + ((t.d1 > t.d2) ? t.d1 : t.d2) + t.d3;
    return 3 + t.d1 + t.d2;
  endfunction

  // Entered and left just after a falling edge with the bridge idle.
  task automatic run_txn(input vec_t t);
    int   cyc, ar_w, r_w, aw_w, w_w, b_w, ar_hs, aw_hs, w_hs;
    bit   ar_d, r_d, aw_d, w_d, b_d, got;
    exp_t e;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0; got = 0;
    bus.req = 1'b1; bus.wr = t.wr; bus.size = t.size; bus.addr = t.addr;
    bus.wdata = t.wdata; bus.wstrb = t.wstrb;
    #1;
    chk1("addr_ok_idle", bus.addr_ok, 1'b1);
    e.wr = t.wr; e.rdata = t.wr ? last_rdata : t.rdat; e.err = t.exp_err;
    sb.push_back(e);
    @(negedge clk); #1;
    if (!t.hold) bus.req = 1'b0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      if (bus.data_ok) begin
        got = 1;
        break;
      end
      chk1("addr_ok_busy", bus.addr_ok, 1'b0);
      clear_inputs();
      if (!t.wr) begin
        chk1("arvalid", bus.arvalid, !ar_d);
        if (bus.arvalid) begin
          chk32("araddr", bus.araddr, t.addr);
          chk32("arsize", {29'd0, bus.arsize}, {29'd0, t.exp_axsize});
        end
        chk1("rready", bus.rready, ar_d);
        if (bus.arvalid && !ar_d) begin
          if (ar_w == t.d1) begin bus.arready = 1'b1; ar_d = 1; ar_hs++; end
          else ar_w++;
        end
        if (bus.rready && !r_d) begin
          if (r_w == t.d2) begin
            bus.rvalid = 1'b1; bus.rdata_i = t.rdat; bus.rresp = t.resp; r_d = 1;
          end else r_w++;
        end
      end else begin
        chk1("awvalid", bus.awvalid, !aw_d);
        chk1("wvalid", bus.wvalid, !w_d);
        if (bus.awvalid) begin
          chk32("awaddr", bus.awaddr, t.addr);
          chk32("awsize", {29'd0, bus.awsize}, {29'd0, t.exp_axsize});
        end
        if (bus.wvalid) begin
          chk32("wdata_o", bus.wdata_o, t.wdata);
          chk32("wstrb_o", {28'd0, bus.wstrb_o}, {28'd0, t.wstrb});
        end
        chk1("bready", bus.bready, aw_d && w_d);
        if (bus.awvalid && !aw_d) begin
          if (aw_w == t.d1) begin bus.awready = 1'b1; aw_d = 1; aw_hs++; end
          else aw_w++;
        end
        if (bus.wvalid && !w_d) begin
          if (w_w == t.d2) begin bus.wready = 1'b1; w_d = 1; w_hs++; end
          else w_w++;
        end
        if (bus.bready && !b_d) begin
          if (b_w == t.d3) begin bus.bvalid = 1'b1; bus.bresp = t.resp; b_d = 1; end
          else b_w++;
        end
      end
      @(negedge clk); #1;
    end
    clear_inputs();
    bus.req = 1'b0;
    if (!got) begin
      chk1("data_ok_timeout", 1'b0, 1'b1);
    end else if (sb.size() == 0) begin
      chk1("data_ok_unexpected", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk32("rdata", bus.rdata, e.rdata);
      chk1("bus_err", bus.bus_err, e.err);
      chk32("latency", cyc, t.exp_lat);
      if (!e.wr) begin
        last_rdata = e.rdata;
        chk32("ar_handshakes", ar_hs, 32'd1);
      end else begin
        chk32("aw_handshakes", aw_hs, 32'd1);
        chk32("w_handshakes", w_hs, 32'd1);
      end
    end
    @(negedge clk); #1;
    chk1("data_ok_pulse_end", bus.data_ok, 1'b0);
    chk1("bus_err_pulse_end", bus.bus_err, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    vec_t rv;
    vecs[0] = '{1'b0, 2'd2, 32'h1FC0_0010, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 2'd0, 1'b0, 3'd2, 1'b0, 3};
    vecs[1] = '{1'b1, 2'd0, 32'hBFAF_F003, 32'h0000_00AA, 4'b1000, 3, 0, 0, 32'h0, 2'd0, 1'b0, 3'd0, 1'b0, 6};
    vecs[2] = '{1'b0, 2'd1, 32'h8000_0102, 32'h0, 4'h0, 5, 0, 0, 32'h1234_5678, 2'd0, 1'b1, 3'd1, 1'b0, 8};
    vecs[3] = '{1'b1, 2'd2, 32'hA000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 32'h0, 2'b10, 1'b0, 3'd2, 1'b1, 3};
    vecs[4] = '{1'b0, 2'd2, 32'hA000_0044, 32'h0, 4'h0, 0, 0, 0, 32'h0BAD_CAFE, 2'd0, 1'b0, 3'd2, 1'b0, 3};
    vecs[5] = '{1'b0, 2'd0, 32'h1FC0_0001, 32'h0, 4'h0, 1, 2, 0, 32'h0000_0055, 2'b01, 1'b0, 3'd0, 1'b1, 6};
    vecs[6] = '{1'b1, 2'd1, 32'h1000_0006, 32'h1234_0000, 4'b1100, 1, 1, 2, 32'h0, 2'd0, 1'b0, 3'd1, 1'b0, 6};
    vecs[7] = '{1'b1, 2'd2, 32'h1000_0010, 32'h5555_AAAA, 4'hF, 0, 3, 1, 32'h0, 2'd0, 1'b0, 3'd2, 1'b0, 7};

    rst = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'd0; bus.addr = 32'h0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0;
    bus.rdata_i = 32'h0; bus.rresp = 2'd0; bus.rlast = 1'b1; bus.bresp = 2'd0;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_arvalid", bus.arvalid, 1'b0);
    chk1("rst_awvalid", bus.awvalid, 1'b0);
    chk1("rst_wvalid", bus.wvalid, 1'b0);
    chk1("rst_rready", bus.rready, 1'b0);
    chk1("rst_bready", bus.bready, 1'b0);
    chk1("rst_data_ok", bus.data_ok, 1'b0);
    chk1("rst_bus_err", bus.bus_err, 1'b0);
    chk32("rst_rdata", bus.rdata, 32'h0);
    chk32("arid", {28'd0, bus.arid}, 32'd1);
    chk32("wid", {28'd0, bus.wid}, 32'd1);
    chk32("arlen", {28'd0, bus.arlen}, 32'd0);
    chk32("awburst", {30'd0, bus.awburst}, 32'd1);
    chk1("wlast", bus.wlast, 1'b1);
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // req withdrawn before the clock edge: nothing may be latched
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'h0000_0700; bus.size = 2'd2;
    #1;
    chk1("addr_ok_drop", bus.addr_ok, 1'b1);
    bus.req = 1'b0;
    @(negedge clk); #1;
    chk1("drop_arvalid", bus.arvalid, 1'b0);
    chk1("drop_awvalid", bus.awvalid, 1'b0);

    // reset while waiting in R for an rvalid that never comes
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'h0000_0800; bus.size = 2'd2;
    @(negedge clk); #1;
    bus.req = 1'b0;
    chk1("rstseq_arvalid", bus.arvalid, 1'b1);
    bus.arready = 1'b1;
    @(negedge clk); #1;
    bus.arready = 1'b0;
    chk1("rstseq_rready", bus.rready, 1'b1);
    bus.bvalid = 1'b1;
    @(negedge clk); #1;
    chk1("bready_outside_B", bus.bready, 1'b0);
    bus.bvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    chk1("midrst_rready", bus.rready, 1'b0);
    chk1("midrst_arvalid", bus.arvalid, 1'b0);
    chk1("midrst_data_ok", bus.data_ok, 1'b0);
    chk32("midrst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk); #1;
    rv = '{1'b0, 2'd2, 32'h0000_0800, 32'h0, 4'h0, 0, 1, 0, 32'hFEED_0001, 2'd0, 1'b0, 3'd2, 1'b0, 4};
    run_txn(rv);

    // alternating read/write stream with random handshake delays
    for (int i = 0; i < 8; i++) begin
      rv.wr         = i[0];
      rv.size       = 2'($urandom_range(0, 2));
      rv.addr       = $urandom;
      rv.wdata      = $urandom;
      rv.wstrb      = 4'($urandom_range(1, 15));
      rv.d1         = $urandom_range(0, 3);
      rv.d2         = $urandom_range(0, 3);
      rv.d3         = $urandom_range(0, 3);
      rv.rdat       = $urandom;
      rv.resp       = (($urandom_range(0, 3)) == 0) ? 2'b10 : 2'b00;
      rv.hold       = 1'($urandom_range(0, 1));
      rv.exp_axsize = {1'b0, rv.size};
      rv.exp_err    = (rv.resp != 2'b00);
      rv.exp_lat    = lat_of(rv);
      run_txn(rv);
    end

    chk32("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
